// File: rtl/pipeline_hazard_controller.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_controller : forwarding selects, load-use stall and branch
// flush control for the 5-stage IF/ID/EX/MEM/WB pipeline.  Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipeline_hazard_controller #(
  parameter int REG_W  = 4,
  parameter int CNT_W  = 16,
  parameter int PC_REG = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic             id_use_rd,
  input  logic             id_rf_e,
  input  logic             id_load,
  input  logic             branch_taken,
  output logic [1:0]       fwd_pa_sel,
  output logic [1:0]       fwd_pb_sel,
  output logic [1:0]       fwd_pd_sel,
  output logic             enable_pc,
  output logic             enable_ifid,
  output logic             nop_sel,
  output logic             flush_ifid,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [1:0]       c_sel_rf  = 2'b00;
  localparam logic [1:0]       c_sel_ex  = 2'b01;
  localparam logic [1:0]       c_sel_mem = 2'b10;
  localparam logic [1:0]       c_sel_wb  = 2'b11;
  localparam logic [REG_W-1:0] c_pc_reg  = REG_W'(PC_REG);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  // Only the EX-stage load flag can create a hazard, so MEM/WB keep rd and rf_e.
  logic [REG_W-1:0] ex_rd_q, mem_rd_q, wb_rd_q;
  logic             ex_rf_e_q, mem_rf_e_q, wb_rf_e_q;
  logic             ex_load_q;
  logic             flushed_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic [REG_W-1:0] ex_rd_d;
  logic             ex_rf_e_d, ex_load_d, flushed_d;
  logic             stall, branch_flush;
  logic             hz_rn, hz_rm, hz_rd;
  logic [1:0]       sel_pa, sel_pb, sel_pd;

  function automatic logic [1:0] fwd_sel(
    input logic             use_src,
    input logic [REG_W-1:0] src,
    input logic [REG_W-1:0] ex_rd,
    input logic             ex_we,
    input logic [REG_W-1:0] mem_rd,
    input logic             mem_we,
    input logic [REG_W-1:0] wb_rd,
    input logic             wb_we
  );
    logic [1:0] sel;
    sel = c_sel_rf;
    if (use_src && (src != c_pc_reg)) begin
      if (ex_we && (ex_rd == src))        sel = c_sel_ex;
      else if (mem_we && (mem_rd == src)) sel = c_sel_mem;
      else if (wb_we && (wb_rd == src))   sel = c_sel_wb;
    end
    return sel;
  endfunction

  function automatic logic load_hz(
    input logic             use_src,
    input logic [REG_W-1:0] src,
    input logic [REG_W-1:0] ex_rd,
    input logic             ex_we,
    input logic             ex_ld
  );
    return use_src && (src != c_pc_reg) && ex_we && ex_ld && (ex_rd == src);
  endfunction

  always_comb begin
    sel_pa = fwd_sel(id_use_rn, id_rn, ex_rd_q, ex_rf_e_q, mem_rd_q, mem_rf_e_q, wb_rd_q, wb_rf_e_q);
    sel_pb = fwd_sel(id_use_rm, id_rm, ex_rd_q, ex_rf_e_q, mem_rd_q, mem_rf_e_q, wb_rd_q, wb_rf_e_q);
    sel_pd = fwd_sel(id_use_rd, id_rd, ex_rd_q, ex_rf_e_q, mem_rd_q, mem_rf_e_q, wb_rd_q, wb_rf_e_q);
    hz_rn  = load_hz(id_use_rn, id_rn, ex_rd_q, ex_rf_e_q, ex_load_q);
    hz_rm  = load_hz(id_use_rm, id_rm, ex_rd_q, ex_rf_e_q, ex_load_q);
    hz_rd  = load_hz(id_use_rd, id_rd, ex_rd_q, ex_rf_e_q, ex_load_q);
    stall        = !flushed_q && (hz_rn || hz_rm || hz_rd);
    branch_flush = branch_taken && !stall && !flushed_q;
    flushed_d    = branch_flush;
    // A stalled consumer or the bubble left by a flush must not enter EX as a writer.
    if (stall || flushed_q) begin
      ex_rd_d   = '0;
      ex_rf_e_d = 1'b0;
      ex_load_d = 1'b0;
    end else begin
      ex_rd_d   = id_rd;
      ex_rf_e_d = id_rf_e;
      ex_load_d = id_load;
    end
  end

  always_comb begin
    fwd_pa_sel  = c_sel_rf;
    fwd_pb_sel  = c_sel_rf;
    fwd_pd_sel  = c_sel_rf;
    enable_pc   = 1'b1;
    enable_ifid = 1'b1;
    nop_sel     = 1'b0;
    flush_ifid  = 1'b0;
    if (!reset) begin
      fwd_pa_sel  = sel_pa;
      fwd_pb_sel  = sel_pb;
      fwd_pd_sel  = sel_pd;
      enable_pc   = !stall;
      enable_ifid = !stall;
      nop_sel     = stall;
      flush_ifid  = branch_flush;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_rd_q     <= '0;
      ex_rf_e_q   <= 1'b0;
      ex_load_q   <= 1'b0;
      mem_rd_q    <= '0;
      mem_rf_e_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_rf_e_q   <= 1'b0;
      flushed_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_rd_q     <= ex_rd_d;
      ex_rf_e_q   <= ex_rf_e_d;
      ex_load_q   <= ex_load_d;
      mem_rd_q    <= ex_rd_q;
      mem_rf_e_q  <= ex_rf_e_q;
      wb_rd_q     <= mem_rd_q;
      wb_rf_e_q   <= mem_rf_e_q;
      flushed_q   <= flushed_d;
      if (stall && !(&stall_cnt_q))
        stall_cnt_q <= stall_cnt_q + c_cnt_one;
      if (branch_flush && !(&flush_cnt_q))
        flush_cnt_q <= flush_cnt_q + c_cnt_one;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

`default_nettype wire

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Hazard and forwarding controller for the 5-stage IF/ID/EX/MEM/WB pipeline.
- Shadows the destination register, RF_E and LOAD of every in-flight instruction.
- Drives the PA/PB/PD forwarding mux selects, PC and IF/ID load enables, the control-signal NOP mux select (S) and the IF/ID flush on taken branches.
- Sits beside the ID stage, between the control unit, condition handler and pipeline registers.

Parameters:
REG_W, 4, register specifier width (I19_I16, I3_I0, I15_I12 fields)
CNT_W, 16, width of stall and flush performance counters
PC_REG, 15, register number never forwarded (RF supplies PC-relative value)

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  synchronous, active-high
id_rn  in  REG_W  ID instruction I19_I16 (PA source)
id_rm  in  REG_W  ID instruction I3_I0 (PB source)
id_rd  in  REG_W  ID instruction I15_I12 (PD source / destination)
id_use_rn  in  1  ID instruction reads Rn
id_use_rm  in  1  ID instruction reads Rm
id_use_rd  in  1  ID instruction reads Rd as store data
id_rf_e  in  1  ID instruction writes register file (control unit RF_E)
id_load  in  1  ID instruction is a load (control unit ID_LOAD)
branch_taken  in  1  condition handler Branch/BranchLink taken, resolved in ID
fwd_pa_sel  out  2  00 RF, 01 EX result, 10 MEM result, 11 WB result
fwd_pb_sel  out  2  same encoding, PB mux
fwd_pd_sel  out  2  same encoding, PD mux
enable_pc  out  1  PC load enable
enable_ifid  out  1  IF/ID load enable
nop_sel  out  1  1 = control mux injects NOP into ID/EX (drives S)
flush_ifid  out  1  1 = IF/ID loads all-zero (NOP) instruction next edge
stall_count  out  CNT_W  saturating count of load-use stall cycles
flush_count  out  CNT_W  saturating count of branch flushes

Behaviour:
- Internal shadow state: {rd, rf_e, load} for EX, MEM, WB stages; advances every rising edge: EX<=ID-entry, MEM<=EX, WB<=MEM.
- ID-entry = {id_rd, id_rf_e, id_load}, except when nop_sel=1 or flush_ifid=1 (previous-cycle flush leaves NOP in ID): entry = {0,0,0}. Track flush with a 1-bit register flushed_q; ID is a bubble when flushed_q=1.
- Forward select per source S in {rn->pa, rm->pb, rd->pd}: if use_S=0 or S==PC_REG -> 00. Else first match in priority EX(rf_e & rd==S)->01, MEM->10, WB->11, else 00. Youngest writer wins.
- Load-use stall: ID valid (flushed_q=0) and any used source (not PC_REG) matches EX.rd with EX.rf_e & EX.load -> stall=1.
- stall=1: enable_pc=0, enable_ifid=0, nop_sel=1, flush_ifid=0; branch_taken ignored this cycle; exactly 1 cycle (load moves to MEM next edge, then forwards via 10).
- branch_taken=1 and stall=0 and flushed_q=0: flush_ifid=1, enable_pc=1, enable_ifid=1; flushed_q<=1 next edge; flush_count++.
- Otherwise: enable_pc=1, enable_ifid=1, nop_sel=0, flush_ifid=0.
- Back-to-back branch: branch_taken while flushed_q=1 is ignored (ID holds the flush bubble).
- Forward selects are combinational from shadow state plus ID inputs; during stall they remain valid but are don't-care downstream.
- Counters saturate at all-ones, no wrap; stall_count increments once per stall cycle.
- Reset (sync, when reset=1 at edge): all shadow rf_e/load/rd = 0, flushed_q=0, counters=0. While reset is high, outputs are forced: enable_pc=1, enable_ifid=1, nop_sel=0, flush_ifid=0, all selects 00. Reset mid-stall cancels the stall; the first post-reset cycle sees empty pipeline.

Test Plan:
- ADD r1 at ID, next ID SUB r2,r1,r3 (use_rn, rn=1) -> fwd_pa_sel=01; next cycle unrelated reader of r1 -> 10; one later -> 11; fourth cycle -> 00.
- LDR r5 (load, rf_e, rd=5) followed by ADD r6,r5,r5 -> 1 cycle enable_pc=0, enable_ifid=0, nop_sel=1, stall_count=1; next cycle fwd_pa_sel=fwd_pb_sel=10, enables 1.
- EX writes r1 and MEM writes r1, ID reads r1 -> sel=01 (EX priority); reader of r15 with EX rd=15 -> sel=00.
- branch_taken=1 -> flush_ifid=1 one cycle, flush_count=1; branch_taken held high next cycle -> flush_ifid=0, count stays 1; the bubble enters EX with rf_e=0 (no forward from it).
- Load-use stall with branch_taken=1 same cycle -> stall wins, flush_ifid=0; reset asserted during stall -> next cycle enables 1, counters 0, selects 00.
- Force stall_count to 16'hFFFF via repeated load-use -> stays 16'hFFFF.
